// File: rtl/sd_pkg.sv
// Shared definitions for the SD block responder: controller states and sector geometry.
package sd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int BYTE_IDX_W   = 9;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RD_REQ,
        RD_WAIT,
        WR_ADDR,
        WR_REQ,
        WR_WAIT,
        DONE
    } sd_state_t;

endpackage

// File: rtl/sd_block_responder.sv
// Sector-level responder: serves 512-byte SD block reads/writes from an external byte-wide store.
module sd_block_responder
    import sd_pkg::*;
#(
    parameter int LBA_BITS  = 16,
    parameter int CAPACITY  = 65536,
    parameter int ACK_DELAY = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             sd_lba,
    input  logic                    sd_rd,
    input  logic                    sd_wr,
    output logic                    sd_ack,
    output logic [BYTE_IDX_W-1:0]   sd_buff_addr,
    output logic [7:0]              sd_buff_dout,
    input  logic [7:0]              sd_buff_din,
    output logic                    sd_buff_wr,
    output logic [LBA_BITS+8:0]     mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    err
);

    localparam int                DLY_W    = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(ACK_DELAY - 1);

    sd_state_t               state;
    logic [LBA_BITS-1:0]     lba_q;
    logic                    op_rd;
    logic                    oor;
    logic [DLY_W-1:0]        dly_cnt;
    logic [BYTE_IDX_W-1:0]   cnt;
    logic                    lba_oor;

    assign lba_oor = (sd_lba >= 32'(CAPACITY));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lba_q        <= '0;
            op_rd        <= 1'b0;
            oor          <= 1'b0;
            dly_cnt      <= '0;
            cnt          <= '0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            err          <= 1'b0;
        end else begin
            sd_buff_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (sd_rd || sd_wr) begin
                        lba_q   <= sd_lba[LBA_BITS-1:0];
                        op_rd   <= sd_rd;
                        oor     <= lba_oor;
                        err     <= err | lba_oor;
                        dly_cnt <= '0;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        sd_ack       <= 1'b1;
                        cnt          <= '0;
                        sd_buff_addr <= '0;
                        state        <= op_rd ? RD_REQ : WR_ADDR;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                RD_REQ: begin
                    mem_addr <= {lba_q, cnt};
                    mem_rd   <= !oor;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Out-of-range sectors complete on the same schedule, returning zeros.
                    if (oor || mem_ready) begin
                        mem_rd       <= 1'b0;
                        sd_buff_dout <= oor ? 8'h00 : mem_rdata;
                        sd_buff_addr <= cnt;
                        sd_buff_wr   <= 1'b1;
                        if (cnt == LAST_BYTE) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= RD_REQ;
                        end
                    end
                end
                WR_ADDR: begin
                    state <= WR_REQ;
                end
                WR_REQ: begin
                    // Buffer data for sd_buff_addr arrives one cycle after the address.
                    mem_wdata <= sd_buff_din;
                    mem_addr  <= {lba_q, cnt};
                    mem_wr    <= !oor;
                    state     <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (oor || mem_ready) begin
                        mem_wr <= 1'b0;
                        if (cnt == LAST_BYTE) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt          <= cnt + 1'b1;
                            sd_buff_addr <= cnt + 1'b1;
                            state        <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder with a behavioural byte store and initiator buffer.
module tb_sd_block_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    sd_block_responder #(
        .LBA_BITS (16),
        .CAPACITY (65536),
        .ACK_DELAY(4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_din (sd_buff_din),
        .sd_buff_wr  (sd_buff_wr),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Store content: byte = addr[7:0] ^ A5, garbage whenever not ready.
    assign mem_rdata = mem_ready ? (mem_addr[7:0] ^ 8'hA5) : 8'h5A;

    int tests    = 0;
    int failures = 0;

    logic        rand_ready = 1'b0;
    logic        exp_zero   = 1'b0;
    logic [15:0] exp_lba    = '0;

    int strobe_cnt, strobe_bad, rd_hs, rd_cycles, rd_drop, addr_bad;
    int wr_hs, wr_bad, both_hi, ack_cycles;
    logic [8:0] last_addr;

    // Memory handshake driver and per-cycle monitor, evaluated on the falling edge.
    initial begin : monitor
        logic       in_req;
        logic       rd_pending;
        int         wait_left;
        logic [8:0] prev_addr;
        logic [7:0] want;
        in_req      = 1'b0;
        rd_pending  = 1'b0;
        wait_left   = 0;
        prev_addr   = '0;
        mem_ready   = 1'b1;
        sd_buff_din = 8'h00;
        forever begin
            @(negedge clk);
            if (!rand_ready) begin
                mem_ready = 1'b1;
            end else if (mem_rd || mem_wr) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    in_req    = 1'b0;
                end else begin
                    mem_ready = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ready = 1'b0;
                in_req    = 1'b0;
            end

            sd_buff_din = ~prev_addr[7:0];
            prev_addr   = sd_buff_addr;

            if (sd_buff_wr) begin
                want = exp_zero ? 8'h00 : (strobe_cnt[7:0] ^ 8'hA5);
                if (sd_buff_addr !== strobe_cnt[8:0] || sd_buff_dout !== want) strobe_bad++;
                last_addr = sd_buff_addr;
                strobe_cnt++;
            end
            if (mem_rd && mem_wr) both_hi++;
            if (mem_rd) rd_cycles++;
            if (sd_ack) ack_cycles++;
            if (rd_pending && !mem_rd) rd_drop++;
            rd_pending = mem_rd && !mem_ready;
            if (mem_rd && mem_ready) begin
                if (mem_addr !== {exp_lba, rd_hs[8:0]}) addr_bad++;
                rd_hs++;
            end
            if (mem_wr && mem_ready) begin
                if (mem_addr !== {exp_lba, wr_hs[8:0]} || mem_wdata !== ~wr_hs[7:0]) wr_bad++;
                wr_hs++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        strobe_cnt = 0; strobe_bad = 0; rd_hs = 0; rd_cycles = 0; rd_drop = 0;
        addr_bad = 0; wr_hs = 0; wr_bad = 0; both_hi = 0; ack_cycles = 0;
        last_addr = '0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_strobes(input string tag, input int target, input int limit);
        int n = 0;
        while (strobe_cnt < target && n < limit) begin
            step();
            n++;
        end
        check({tag, "_reached"}, {31'd0, strobe_cnt >= target}, 32'd1);
    endtask

    initial begin : stimulus
        clear_stats();
        reset_n = 1'b0;
        sd_lba  = '0;
        sd_rd   = 1'b0;
        sd_wr   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_ack",   {31'd0, sd_ack},     32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_err",   {31'd0, err},        32'd0);
        check("rst_memrd", {31'd0, mem_rd},     32'd0);
        check("rst_memwr", {31'd0, mem_wr},     32'd0);
        check("rst_baddr", {23'd0, sd_buff_addr}, 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Read lba 5 with mem_ready tied high
        exp_lba = 16'd5; exp_zero = 1'b0; rand_ready = 1'b0;
        clear_stats();
        sd_lba = 32'd5; sd_rd = 1'b1;
        step();
        check("rd_busy", {31'd0, busy}, 32'd1);
        repeat (3) step();
        check("rd_ack_early", {31'd0, sd_ack}, 32'd0);
        step();
        check("rd_ack_rise", {31'd0, sd_ack}, 32'd1);
        sd_rd = 1'b0;
        wait_idle("rd", 3000);
        check("rd_strobes",  strobe_cnt, 32'd512);
        check("rd_data_bad", strobe_bad, 32'd0);
        check("rd_addr_bad", addr_bad,   32'd0);
        check("rd_ack_len",  ack_cycles, 32'd1024);
        check("rd_ack_fall", {31'd0, sd_ack}, 32'd0);
        check("rd_err",      {31'd0, err},    32'd0);
        repeat (2) step();

        // Write lba 3, buffer byte i = ~i
        exp_lba = 16'd3;
        clear_stats();
        sd_lba = 32'd3; sd_wr = 1'b1;
        repeat (5) step();
        check("wr_ack_rise", {31'd0, sd_ack}, 32'd1);
        sd_wr = 1'b0;
        wait_idle("wr", 3000);
        check("wr_count",   wr_hs,      32'd512);
        check("wr_bad",     wr_bad,     32'd0);
        check("wr_strobes", strobe_cnt, 32'd0);
        check("wr_memrd",   rd_cycles,  32'd0);
        check("wr_ack_len", ack_cycles, 32'd1536);
        check("wr_ack_fall", {31'd0, sd_ack}, 32'd0);
        check("wr_both",    both_hi,    32'd0);
        repeat (2) step();

        // Read lba 7 with 0-3 random wait cycles
        exp_lba = 16'd7; rand_ready = 1'b1;
        clear_stats();
        sd_lba = 32'd7; sd_rd = 1'b1;
        repeat (5) step();
        sd_rd = 1'b0;
        wait_idle("rnd", 5000);
        check("rnd_strobes",  strobe_cnt, 32'd512);
        check("rnd_data_bad", strobe_bad, 32'd0);
        check("rnd_hs",       rd_hs,      32'd512);
        check("rnd_addr_bad", addr_bad,   32'd0);
        check("rnd_rd_drop",  rd_drop,    32'd0);
        check("rnd_both",     both_hi,    32'd0);
        rand_ready = 1'b0;
        repeat (2) step();

        // Out-of-range read lba 70000
        exp_zero = 1'b1; exp_lba = 16'd0;
        clear_stats();
        sd_lba = 32'd70000; sd_rd = 1'b1;
        step();
        check("oor_err_set", {31'd0, err}, 32'd1);
        repeat (3) step();
        check("oor_ack_early", {31'd0, sd_ack}, 32'd0);
        step();
        check("oor_ack_rise", {31'd0, sd_ack}, 32'd1);
        sd_rd = 1'b0;
        wait_idle("oor", 3000);
        check("oor_strobes",  strobe_cnt, 32'd512);
        check("oor_data_bad", strobe_bad, 32'd0);
        check("oor_memrd",    rd_cycles,  32'd0);
        check("oor_ack_len",  ack_cycles, 32'd1024);
        repeat (2) step();

        // Read and write together, request dropped at byte 100
        exp_zero = 1'b0; exp_lba = 16'd9;
        clear_stats();
        sd_lba = 32'd9; sd_rd = 1'b1; sd_wr = 1'b1;
        wait_strobes("both", 100, 1000);
        sd_rd = 1'b0; sd_wr = 1'b0;
        wait_idle("both", 3000);
        check("both_strobes",  strobe_cnt, 32'd512);
        check("both_last",     {23'd0, last_addr}, 32'd511);
        check("both_data_bad", strobe_bad, 32'd0);
        check("both_memwr",    wr_hs,      32'd0);
        check("both_err_held", {31'd0, err}, 32'd1);
        repeat (2) step();

        // Reset at byte 200 of a read with sd_rd held
        exp_lba = 16'd5;
        clear_stats();
        sd_lba = 32'd5; sd_rd = 1'b1;
        wait_strobes("mid", 200, 1000);
        reset_n = 1'b0;
        #1;
        check("mid_ack",   {31'd0, sd_ack},     32'd0);
        check("mid_bwr",   {31'd0, sd_buff_wr}, 32'd0);
        check("mid_memrd", {31'd0, mem_rd},     32'd0);
        check("mid_busy",  {31'd0, busy},       32'd0);
        check("mid_err",   {31'd0, err},        32'd0);
        check("mid_dout",  {24'd0, sd_buff_dout}, 32'd0);
        check("mid_baddr", {23'd0, sd_buff_addr}, 32'd0);
        clear_stats();
        repeat (3) step();
        check("mid_quiet", strobe_cnt + rd_cycles, 32'd0);
        reset_n = 1'b1;
        clear_stats();
        repeat (4) step();
        check("restart_ack_early", {31'd0, sd_ack}, 32'd0);
        step();
        check("restart_ack_rise", {31'd0, sd_ack}, 32'd1);
        sd_rd = 1'b0;
        wait_idle("restart", 3000);
        check("restart_strobes",  strobe_cnt, 32'd512);
        check("restart_data_bad", strobe_bad, 32'd0);
        check("restart_addr_bad", addr_bad,   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/sd_block_responder.md
SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 SHALL have parameter LBA_BITS, default 16, meaning number of LBA bits used to address backing store.
REQ-002 SHALL have parameter CAPACITY, default 65536, meaning number of valid 512-byte sectors.
REQ-003 SHALL have parameter ACK_DELAY, default 4, meaning clk cycles from request capture to sd_ack rise (minimum 1).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sd_lba  input  32  sector number, sampled at request capture.
REQ-007 SHALL have port sd_rd  input  1  read request level from initiator.
REQ-008 SHALL have port sd_wr  input  1  write request level from initiator.
REQ-009 SHALL have port sd_ack  output  1  high for the whole transfer.
REQ-010 SHALL have port sd_buff_addr  output  9  byte index within sector.
REQ-011 SHALL have port sd_buff_dout  output  8  read data to initiator buffer.
REQ-012 SHALL have port sd_buff_din  input  8  write data from initiator buffer, valid one cycle after sd_buff_addr.
REQ-013 SHALL have port sd_buff_wr  output  1  one-cycle strobe, dout valid at sd_buff_addr.
REQ-014 SHALL have ports mem_addr (output, LBA_BITS+9), mem_rd (output, 1), mem_wr (output, 1), mem_wdata (output, 8), mem_rdata (input, 8), mem_ready (input, 1): backing-store byte port; rd/wr held until mem_ready.
REQ-015 SHALL have ports busy (output, 1, state != IDLE) and err (output, 1, sticky out-of-range flag).

Function
REQ-016 SHALL implement states IDLE, DELAY, RD_REQ, RD_WAIT, WR_ADDR, WR_REQ, WR_WAIT, DONE.
REQ-017 In IDLE with sd_rd or sd_wr high, SHALL latch sd_lba and op, and enter DELAY; sd_rd wins if both are high.
REQ-018 DELAY SHALL count ACK_DELAY cycles, then raise sd_ack, clear the byte counter, and go to RD_REQ (read) or WR_ADDR (write).
REQ-019 Read: RD_REQ SHALL assert mem_rd with mem_addr = {lba[LBA_BITS-1:0], cnt}; RD_WAIT SHALL hold it until mem_ready, then drive sd_buff_dout = mem_rdata, sd_buff_addr = cnt, and sd_buff_wr = 1 for exactly one cycle.
REQ-020 Write: WR_ADDR SHALL drive sd_buff_addr = cnt for one cycle; WR_REQ SHALL capture sd_buff_din into mem_wdata and assert mem_wr; WR_WAIT SHALL hold until mem_ready.
REQ-021 Byte counter SHALL be 9 bits; after byte 511 it SHALL go to DONE rather than wrap.
REQ-022 DONE SHALL drop sd_ack and return to IDLE next cycle; sd_rd/sd_wr still high in IDLE SHALL start a new transfer.
REQ-023 Request deassertion during DELAY or the transfer SHALL be ignored; the transfer completes all 512 bytes.
REQ-024 If latched lba >= CAPACITY: reads SHALL return 8'h00 per byte without mem_rd, writes SHALL discard without mem_wr, err SHALL set, and sd_ack timing SHALL stay identical.
REQ-025 mem_rd and mem_wr SHALL never be high together; sd_buff_wr SHALL never pulse during a write transfer.
REQ-026 Throughput: with mem_ready tied high, a read SHALL take 2 cycles/byte and a write 3 cycles/byte.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, and clear sd_ack, sd_buff_wr, mem_rd, mem_wr, busy, err, counter, sd_buff_addr, sd_buff_dout and mem_wdata to 0.
REQ-028 Reset mid-transfer SHALL abort with no further strobes; after release, a held request SHALL restart from byte 0.

Structure
REQ-029 Package sd_pkg SHALL hold the state enum, SECTOR_BYTES=512, and BYTE_IDX_W=9.
REQ-030 The block SHALL be a single module with no sub-modules; the backing store is external.

Verification
REQ-031 Read lba 5, mem pattern byte = addr[7:0]^8'hA5, mem_ready high -> sd_ack rises 4 cycles after sd_rd, 512 sd_buff_wr strobes with dout[i] = i[7:0]^8'hA5, sd_ack high for 1024 cycles.
REQ-032 Write lba 3, initiator buffer byte i = ~i[7:0] -> mem writes addr {3, i} = ~i[7:0] for i = 0..511, no sd_buff_wr, sd_ack falls, busy low.
REQ-033 Read with mem_ready random 0-3 wait cycles -> identical data, mem_rd held until ready, never both mem_rd and mem_wr.
REQ-034 Read lba 70000 (> CAPACITY) -> 512 strobes of 8'h00, no mem_rd, err = 1 until reset.
REQ-035 sd_rd and sd_wr raised together -> read performed; sd_rd dropped at byte 100 -> transfer still ends at byte 511.
REQ-036 reset_n pulsed low at byte 200 of a read -> outputs zero immediately; held sd_rd restarts at byte 0 after the ACK_DELAY.
